// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm LED driver family: fader state encoding
// and the default counter width common to pwm and pwm_fader.
package pwm_pkg;

  localparam int CTR_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    HOLD_HI,
    FALL,
    HOLD_LO
  } fader_state_t;

endpackage

// File: rtl/pwm_fader.sv
// Breathing-profile duty generator for a downstream pwm instance; compare only
// changes at pwm period boundaries so no period is ever glitched.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int CTR_LEN    = CTR_LEN_DEFAULT,
  parameter int DIV_LEN    = 16,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CTR_LEN-1:0] step,
  input  logic [CTR_LEN-1:0] min_level,
  input  logic [CTR_LEN-1:0] max_level,
  output logic [CTR_LEN-1:0] compare,
  output logic               rising,
  output logic               period_start
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  fader_state_t       state;
  logic [CTR_LEN-1:0] ctr;
  logic [DIV_LEN-1:0] div;
  logic [7:0]         hold_cnt;
  logic               tick_pending;

  logic               boundary;
  logic               tick;
  logic               do_update;
  logic               park;
  logic [CTR_LEN:0]   rise_sum;
  logic [CTR_LEN:0]   fall_floor;

  assign boundary  = &ctr;
  assign tick      = &div;
  assign do_update = boundary && (tick_pending || tick);
  assign park      = !enable || (min_level >= max_level);

  // Sums are one bit wider so saturation tests never see a wrapped value.
  assign rise_sum   = {1'b0, compare} + {1'b0, step};
  assign fall_floor = {1'b0, min_level} + {1'b0, step};

  assign rising       = (state == RISE) || (state == HOLD_HI);
  assign period_start = (ctr == '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ctr          <= '0;
      div          <= '0;
      hold_cnt     <= '0;
      tick_pending <= 1'b0;
      compare      <= '0;
    end else begin
      ctr <= ctr + 1'b1;
      div <= div + 1'b1;

      if (do_update) begin
        tick_pending <= 1'b0;
      end else if (tick) begin
        tick_pending <= 1'b1;
      end

      if (do_update) begin
        if (park) begin
          state   <= IDLE;
          compare <= min_level;
        end else begin
          case (state)
            IDLE: begin
              compare <= min_level;
              state   <= RISE;
            end
            RISE: begin
              if (rise_sum >= {1'b0, max_level}) begin
                compare  <= max_level;
                hold_cnt <= '0;
                state    <= HOLD_HI;
              end else begin
                compare <= rise_sum[CTR_LEN-1:0];
              end
            end
            HOLD_HI: begin
              hold_cnt <= hold_cnt + 8'd1;
              if (hold_cnt == HOLD_LAST) state <= FALL;
            end
            FALL: begin
              if ({1'b0, compare} <= fall_floor) begin
                compare  <= min_level;
                hold_cnt <= '0;
                state    <= HOLD_LO;
              end else begin
                compare <= compare - step;
              end
            end
            HOLD_LO: begin
              hold_cnt <= hold_cnt + 8'd1;
              if (hold_cnt == HOLD_LAST) state <= RISE;
            end
            default: begin
              state   <= IDLE;
              compare <= min_level;
            end
          endcase
        end
      end
    end
  end

endmodule
